// File: rtl/decomp_fetch_sequencer_if.sv
// CPU fetch, compressed-memory and token-table signal bundle for decomp_fetch_sequencer.
// master = the sequencer; slave = the CPU/memory/table side that answers it.
interface decomp_fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req;
  logic [WIDTH-1:0] pc_cpu;
  logic             cpu_busy;
  logic             resp_valid;
  logic [WIDTH-1:0] instr_out;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_rdata;
  logic             tbl_rd;
  logic [WIDTH-1:0] tbl_addr;
  logic [WIDTH-1:0] tbl_data1;
  logic [WIDTH-1:0] tbl_data2;

  modport master (
    input  cpu_req, pc_cpu, mem_valid, mem_rdata, tbl_data1, tbl_data2,
    output cpu_busy, resp_valid, instr_out, mem_req, mem_addr, tbl_rd, tbl_addr
  );

  modport slave (
    output cpu_req, pc_cpu, mem_valid, mem_rdata, tbl_data1, tbl_data2,
    input  cpu_busy, resp_valid, instr_out, mem_req, mem_addr, tbl_rd, tbl_addr
  );
endinterface

// File: rtl/decomp_fetch_sequencer.sv
// Compressed-fetch sequencer: plain word answers 1 cycle after mem_valid, token 2, held half 1 cycle after cpu_req.
// CPU requests are ignored while cpu_busy; memory is waited on indefinitely. DECOMP_STATS_EN adds token/redirect counters.
module decomp_fetch_sequencer #(
  parameter int                    WIDTH      = 32,
  parameter int                    PCADD      = 4,
  parameter int                    ENCODE_LEN = 4,
  parameter logic [ENCODE_LEN-1:0] OPCODE     = 4'b1111
) (
  input  logic                    clk,
  input  logic                    reset,
  decomp_fetch_sequencer_if.master bus
`ifdef DECOMP_STATS_EN
  ,
  output logic [15:0]             stat_tokens,
  output logic [15:0]             stat_redirects
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, LOOKUP} state_t;

  localparam logic [WIDTH-1:0] INC = WIDTH'(PCADD);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cpc, pc_req, exp_pc, held;
  logic             exp_valid, held_valid;
  logic             req_take, hit_held, hit_seq, redirect, is_token, fetch_done;

  assign req_take   = (state == IDLE) && bus.cpu_req;
  assign hit_held   = held_valid && (bus.pc_cpu == exp_pc);
  assign hit_seq    = exp_valid && (bus.pc_cpu == exp_pc);
  assign redirect   = req_take && !hit_held && !hit_seq;
  assign is_token   = (bus.mem_rdata[WIDTH-1 -: ENCODE_LEN] == OPCODE);
  assign fetch_done = (state == FETCH) && bus.mem_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cpu_req && !hit_held) state_nxt = FETCH;
      FETCH:   if (bus.mem_valid) state_nxt = is_token ? LOOKUP : IDLE;
      LOOKUP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_busy = (state != IDLE);
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.tbl_rd   = 1'b0;
    bus.tbl_addr = '0;
    if (state == FETCH) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = cpc;
      // Table strobe fires in the same cycle the token word arrives; data is read in LOOKUP.
      if (bus.mem_valid && is_token) begin
        bus.tbl_rd   = 1'b1;
        bus.tbl_addr = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpc            <= '0;
      pc_req         <= '0;
      exp_pc         <= '0;
      exp_valid      <= 1'b0;
      held           <= '0;
      held_valid     <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.instr_out  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_take) begin
            pc_req <= bus.pc_cpu;
            if (hit_held) begin
              bus.instr_out  <= held;
              bus.resp_valid <= 1'b1;
              held_valid     <= 1'b0;
              exp_pc         <= bus.pc_cpu + INC;
            end else if (redirect) begin
              cpc        <= bus.pc_cpu;
              held_valid <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (fetch_done && !is_token) begin
            bus.instr_out  <= bus.mem_rdata;
            bus.resp_valid <= 1'b1;
            cpc            <= cpc + INC;
            exp_pc         <= pc_req + INC;
            exp_valid      <= 1'b1;
          end
        end
        LOOKUP: begin
          // Expansions are delivered verbatim even if they look like tokens themselves.
          bus.instr_out  <= bus.tbl_data1;
          bus.resp_valid <= 1'b1;
          held           <= bus.tbl_data2;
          held_valid     <= 1'b1;
          cpc            <= cpc + INC;
          exp_pc         <= pc_req + INC;
          exp_valid      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DECOMP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_tokens    <= '0;
      stat_redirects <= '0;
    end else begin
      if (fetch_done && is_token && (stat_tokens != 16'hFFFF))
        stat_tokens <= stat_tokens + 16'd1;
      if (redirect && (stat_redirects != 16'hFFFF))
        stat_redirects <= stat_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decomp_fetch_sequencer.sv
// Directed vector bench for decomp_fetch_sequencer: table of fetch transactions plus reset-in-LOOKUP sequence.
module tb_decomp_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decomp_fetch_sequencer_if #(.WIDTH(32)) bus ();

`ifdef DECOMP_STATS_EN
  logic [15:0] stat_tokens, stat_redirects;
`endif

  decomp_fetch_sequencer #(
    .WIDTH(32), .PCADD(4), .ENCODE_LEN(4), .OPCODE(4'b1111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DECOMP_STATS_EN
    ,
    .stat_tokens    (stat_tokens),
    .stat_redirects (stat_redirects)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] t1;
    logic [31:0] t2;
    int          stall;
    bit          inject;
    bit          exp_mem;
    logic [31:0] exp_maddr;
    bit          exp_tbl;
    logic [31:0] exp_taddr;
    logic [31:0] exp_instr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered and left on a falling edge; drives one cpu_req and plays memory/table until the response.
  task automatic run_vec(input int idx, input vec_t v);
    logic        saw_mem, saw_tbl, got, busy_ok, tbl_next;
    logic [31:0] maddr, taddr, instr;
    int          lat, since, stall_left;
    saw_mem = 0; saw_tbl = 0; got = 0; busy_ok = 1; tbl_next = 0;
    maddr = 0; taddr = 0; instr = 0; lat = -1; since = 0; stall_left = v.stall;
    bus.cpu_req = 1'b1;
    bus.pc_cpu  = v.pc;
    @(negedge clk);
    for (int c = 0; c < 20 && !got; c++) begin
      since++;
      bus.cpu_req   = 1'b0;
      bus.mem_valid = 1'b0;
      bus.tbl_data1 = tbl_next ? v.t1 : 32'h0;
      bus.tbl_data2 = tbl_next ? v.t2 : 32'h0;
      tbl_next = 0;
      #1;
      if (bus.resp_valid) begin
        got   = 1;
        instr = bus.instr_out;
        lat   = since;
      end else begin
        if (!bus.cpu_busy) busy_ok = 0;
        if (bus.mem_req && !saw_mem) begin
          if (stall_left > 0) begin
            if (v.inject && stall_left == v.stall) begin
              bus.cpu_req = 1'b1;
              bus.pc_cpu  = 32'h999;
            end
            stall_left--;
          end else begin
            saw_mem       = 1;
            maddr         = bus.mem_addr;
            bus.mem_valid = 1'b1;
            bus.mem_rdata = v.word;
            since         = 0;
            #1;
            if (bus.tbl_rd) begin
              saw_tbl  = 1;
              taddr    = bus.tbl_addr;
              tbl_next = 1;
            end
          end
        end
        @(negedge clk);
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d_timeout: got no resp_valid expected resp within 20 cycles", idx);
    end else begin
      chk($sformatf("v%0d_mem_req", idx), 32'(saw_mem), 32'(v.exp_mem));
      if (v.exp_mem) chk($sformatf("v%0d_mem_addr", idx), maddr, v.exp_maddr);
      chk($sformatf("v%0d_tbl_rd", idx), 32'(saw_tbl), 32'(v.exp_tbl));
      if (v.exp_tbl) chk($sformatf("v%0d_tbl_addr", idx), taddr, v.exp_taddr);
      chk($sformatf("v%0d_instr", idx), instr, v.exp_instr);
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_busy", idx), 32'(busy_ok), 32'd1);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_pulse", idx), 32'(bus.resp_valid), 32'd0);
    end
  endtask

  initial begin
    //            pc            word          t1            t2           st inj mem maddr         tbl taddr         instr         lat
    vecs[0]  = '{32'h100,      32'h00A00093, 32'h0,        32'h0,        0, 0, 1, 32'h100,      0, 32'h0,        32'h00A00093, 1};
    vecs[1]  = '{32'h104,      32'h00B00113, 32'h0,        32'h0,        0, 0, 1, 32'h104,      0, 32'h0,        32'h00B00113, 1};
    vecs[2]  = '{32'h200,      32'hF0000008, 32'h11111111, 32'h22222222, 0, 0, 1, 32'h200,      1, 32'hF0000008, 32'h11111111, 2};
    vecs[3]  = '{32'h204,      32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h22222222, 1};
    vecs[4]  = '{32'h208,      32'h00C00193, 32'h0,        32'h0,        0, 0, 1, 32'h204,      0, 32'h0,        32'h00C00193, 1};
    vecs[5]  = '{32'h20C,      32'hF00000AA, 32'h33333333, 32'h44444444, 0, 0, 1, 32'h208,      1, 32'hF00000AA, 32'h33333333, 2};
    vecs[6]  = '{32'h400,      32'h00D00213, 32'h0,        32'h0,        0, 0, 1, 32'h400,      0, 32'h0,        32'h00D00213, 1};
    vecs[7]  = '{32'h404,      32'h00000055, 32'h0,        32'h0,        0, 0, 1, 32'h404,      0, 32'h0,        32'h00000055, 1};
    vecs[8]  = '{32'h408,      32'h00F00313, 32'h0,        32'h0,        3, 1, 1, 32'h408,      0, 32'h0,        32'h00F00313, 1};
    vecs[9]  = '{32'h40C,      32'hF0000010, 32'hF1234567, 32'hFABCDEF0, 0, 0, 1, 32'h40C,      1, 32'hF0000010, 32'hF1234567, 2};
    vecs[10] = '{32'h410,      32'h12345678, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'hFABCDEF0, 1};
    vecs[11] = '{32'hFFFFFFFC, 32'h00100093, 32'h0,        32'h0,        0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h00100093, 1};
    vecs[12] = '{32'h0,        32'h00200113, 32'h0,        32'h0,        0, 0, 1, 32'h0,        0, 32'h0,        32'h00200113, 1};
    vecs[13] = '{32'h4,        32'h00300193, 32'h0,        32'h0,        0, 0, 1, 32'h4,        0, 32'h0,        32'h00300193, 1};

    bus.cpu_req = 0; bus.pc_cpu = 0; bus.mem_valid = 0; bus.mem_rdata = 0;
    bus.tbl_data1 = 0; bus.tbl_data2 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_instr_out",  bus.instr_out,       32'd0);
    chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
    chk("rst_mem_addr",   bus.mem_addr,        32'd0);
    chk("rst_tbl_rd",     32'(bus.tbl_rd),     32'd0);
    chk("rst_tbl_addr",   bus.tbl_addr,        32'd0);
    chk("rst_cpu_busy",   32'(bus.cpu_busy),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Reset while in LOOKUP: held half must not survive, next request refetches.
    bus.cpu_req = 1'b1;
    bus.pc_cpu  = 32'h600;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("lk_mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'hF0000020;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.tbl_data1 = 32'h77777777;
    bus.tbl_data2 = 32'h88888888;
    reset = 1'b1;
    #1;
    chk("lk_busy_in_lookup", 32'(bus.cpu_busy), 32'd1);
    @(negedge clk);
    #1;
    chk("lk_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("lk_rst_cpu_busy",   32'(bus.cpu_busy),   32'd0);
    chk("lk_rst_instr_out",  bus.instr_out,       32'd0);
    reset = 1'b0;
    bus.tbl_data1 = 32'h0;
    bus.tbl_data2 = 32'h0;
    @(negedge clk);
    run_vec(14, '{32'h604, 32'h00E00293, 32'h0, 32'h0, 0, 0, 1, 32'h604, 0, 32'h0, 32'h00E00293, 1});

`ifdef DECOMP_STATS_EN
    chk("stat_tokens",    32'(stat_tokens),    32'd0);
    chk("stat_redirects", 32'(stat_redirects), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
